// File: rtl/table_fsm_if.sv
// rtl/table_fsm_if.sv - control, table-write and status bundle of table_fsm
interface table_fsm_if #(
    parameter int IN_W  = 2,
    parameter int ST_W  = 3,
    parameter int OUT_W = 3
);
    logic                   en;
    logic [IN_W-1:0]        a;
    logic                   wr_en;
    logic [ST_W+IN_W-1:0]   wr_addr;
    logic [ST_W+OUT_W-1:0]  wr_data;
    logic                   trap_en;
    logic [ST_W-1:0]        trap_state;
    logic                   resume;
    logic [ST_W-1:0]        state;
    logic [OUT_W-1:0]       saida;
    logic                   trapped;
    logic [15:0]            steps;

    modport master (
        output en, a, wr_en, wr_addr, wr_data, trap_en, trap_state, resume,
        input  state, saida, trapped, steps
    );

    modport slave (
        input  en, a, wr_en, wr_addr, wr_data, trap_en, trap_state, resume,
        output state, saida, trapped, steps
    );
endinterface

// File: rtl/table_fsm.sv
// rtl/table_fsm.sv - programmable table-driven state machine with trap/resume
module table_fsm #(
    parameter int IN_W  = 2,
    parameter int ST_W  = 3,
    parameter int OUT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    table_fsm_if.slave  bus
);
    localparam int AW    = ST_W + IN_W;
    localparam int DW    = ST_W + OUT_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} ctl_t;

    // Entries never written read back as the identity transition, so the
    // table has a defined power-up image that reset leaves untouched.
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] written = '0;

    logic [AW-1:0]          lookup_addr;
    logic [ST_W-1:0]        entry_next;
    logic [OUT_W-1:0]       entry_out;
    logic [OUT_W+ST_W-1:0]  state_ext;

    ctl_t ctl, ctl_next;
    logic advance;

    logic [ST_W-1:0]  state_q;
    logic [OUT_W-1:0] saida_q;
    logic [15:0]      steps_q;

    assign lookup_addr = {state_q, bus.a};
    assign state_ext   = {{OUT_W{1'b0}}, state_q};

    always_comb begin
        entry_next = state_q;
        entry_out  = state_ext[OUT_W-1:0];
        if (written[lookup_addr]) begin
            entry_next = mem[lookup_addr][DW-1:OUT_W];
            entry_out  = mem[lookup_addr][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr]     <= bus.wr_data;
            written[bus.wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ctl <= RUN;
        else       ctl <= ctl_next;
    end

    always_comb begin
        ctl_next = ctl;
        case (ctl)
            RUN:  if (advance && bus.trap_en && entry_next == bus.trap_state) ctl_next = TRAP;
            TRAP: if (bus.resume) ctl_next = RUN;
            default: ctl_next = RUN;
        endcase
    end

    always_comb begin
        advance     = bus.en && (ctl == RUN);
        bus.trapped = (ctl == TRAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            saida_q <= '0;
            steps_q <= '0;
        end else if (advance) begin
            state_q <= entry_next;
            saida_q <= entry_out;
            if (steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
        end
    end

    assign bus.state = state_q;
    assign bus.saida = saida_q;
    assign bus.steps = steps_q;
endmodule
